vx_data_access_wb: RTL and testbench

- Next-generation cache bank data store: multi-way, multi-port, write-back capable.
- Holds line data for NUM_WAYS ways, with one per-byte dirty mask per line.
- Supports fill, partial-word writes from up to NUM_PORTS lanes, registered reads, and eviction readout of a line together with its dirty mask.
- Sits between the bank's tag-access stage and its response/memory-request stages.

---
 rtl/vx_data_access_wb.sv | 85 ++++++++
 tb/tb_vx_data_access_wb.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/vx_data_access_wb.sv
// vx_data_access_wb: multi-way write-back cache bank data store; fill/masked-write/read/evict in, registered read_data and evict line+dirty mask out
module vx_data_access_wb #(
  parameter int NUM_WAYS = 4,
  parameter int LINES_PER_WAY = 64,
  parameter int WORDS_PER_LINE = 4,
  parameter int WORD_SIZE = 4,
  parameter int NUM_PORTS = 2,
  parameter int WRITE_ENABLE = 1,
  localparam int AW = $clog2(LINES_PER_WAY),
  localparam int WAYW = NUM_WAYS > 1 ? $clog2(NUM_WAYS) : 1,
  localparam int WSELW = WORDS_PER_LINE > 1 ? $clog2(WORDS_PER_LINE) : 1,
  localparam int DW = 8 * WORD_SIZE,
  localparam int LB = WORDS_PER_LINE * WORD_SIZE
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  stall,
  input  logic                                  read,
  input  logic                                  write,
  input  logic                                  fill,
  input  logic                                  evict,
  input  logic [AW-1:0]                         addr,
  input  logic [WAYW-1:0]                       way_sel,
  input  logic [NUM_PORTS-1:0][WSELW-1:0]       wsel,
  input  logic [NUM_PORTS-1:0]                  pmask,
  input  logic [NUM_PORTS-1:0][WORD_SIZE-1:0]   byteen,
  input  logic [NUM_PORTS-1:0][DW-1:0]          write_data,
  input  logic [WORDS_PER_LINE-1:0][DW-1:0]     fill_data,
  output logic                                  read_valid,
  output logic [NUM_PORTS-1:0][DW-1:0]          read_data,
  output logic                                  evict_valid,
  output logic [WORDS_PER_LINE-1:0][DW-1:0]     evict_data,
  output logic [LB-1:0]                         evict_byteen
);
  localparam int NLINES = NUM_WAYS * LINES_PER_WAY;
  localparam int IDXW = $clog2(NLINES);
  logic [WORDS_PER_LINE-1:0][DW-1:0] mem [NLINES];
  logic [LB-1:0] dirty [NLINES];
  logic [IDXW-1:0] idx;
  logic [WORDS_PER_LINE-1:0][DW-1:0] cur, wline;
  logic [LB-1:0] wmask;
  logic do_fill, do_wr, do_ev, do_rd;
  function automatic int wix(input logic [WSELW-1:0] s);
    return WORDS_PER_LINE > 1 ? int'(s) : 0;
  endfunction
  assign idx = IDXW'((NUM_WAYS > 1 ? int'(way_sel) : 0) * LINES_PER_WAY + int'(addr));
  assign cur = mem[idx];
  assign do_fill = !stall && fill;
  assign do_wr = !stall && !fill && write && (WRITE_ENABLE != 0);
  assign do_ev = !stall && !fill && !write && evict;
  assign do_rd = !stall && !fill && !write && !evict && read;
  always_comb begin
    wline = cur;
    wmask = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      for (int b = 0; b < WORD_SIZE; b++)
        if (pmask[i] && byteen[i][b]) begin
          wline[wix(wsel[i])][b*8 +: 8] = write_data[i][b*8 +: 8];
          wmask[wix(wsel[i])*WORD_SIZE + b] = 1'b1;
        end
  end
  always_ff @(posedge clk)
    if (do_fill) mem[idx] <= fill_data;
    else if (do_wr) mem[idx] <= wline;
  always_ff @(posedge clk or negedge reset)
    if (!reset) for (int n = 0; n < NLINES; n++) dirty[n] <= '0;
    else if (do_fill || do_ev) dirty[idx] <= '0;
    else if (do_wr) dirty[idx] <= dirty[idx] | wmask;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      read_valid <= 1'b0;
      evict_valid <= 1'b0;
      read_data <= '0;
      evict_data <= '0;
      evict_byteen <= '0;
    end else if (!stall) begin
      read_valid <= do_rd;
      evict_valid <= do_ev;
      if (do_rd) for (int i = 0; i < NUM_PORTS; i++) read_data[i] <= pmask[i] ? cur[wix(wsel[i])] : '0;
      if (do_ev) begin
        evict_data <= cur;
        evict_byteen <= dirty[idx];
      end
    end
endmodule

// File: tb/tb_vx_data_access_wb.sv
// tb_vx_data_access_wb: scoreboard bench with byte-level reference model for vx_data_access_wb
module tb_vx_data_access_wb;
  localparam int NW = 4, NL = 64, WPL = 4, WS = 4, NP = 2, DW = 32, LB = 16;
  logic clk = 0, reset = 0, stall = 0, read = 0, write = 0, fill = 0, evict = 0;
  logic [5:0] addr = '0;
  logic [1:0] way_sel = '0;
  logic [NP-1:0][1:0] wsel = '0;
  logic [NP-1:0] pmask = '0;
  logic [NP-1:0][WS-1:0] byteen = '0;
  logic [NP-1:0][DW-1:0] write_data = '0;
  logic [WPL-1:0][DW-1:0] fill_data = '0;
  logic read_valid, evict_valid;
  logic [NP-1:0][DW-1:0] read_data;
  logic [WPL-1:0][DW-1:0] evict_data;
  logic [LB-1:0] evict_byteen;
  vx_data_access_wb dut (.clk(clk), .reset(reset), .stall(stall), .read(read), .write(write), .fill(fill),
    .evict(evict), .addr(addr), .way_sel(way_sel), .wsel(wsel), .pmask(pmask), .byteen(byteen),
    .write_data(write_data), .fill_data(fill_data), .read_valid(read_valid), .read_data(read_data),
    .evict_valid(evict_valid), .evict_data(evict_data), .evict_byteen(evict_byteen));
  always #5 clk = ~clk;
  typedef struct { logic [WPL*DW-1:0] d; logic [LB-1:0] m; } ev_t;
  logic [7:0] mdat [NW][NL][LB];
  bit mdirty [NW][NL][LB];
  logic [NP*DW-1:0] rq [$];
  ev_t eq [$];
  logic [NP*DW-1:0] rlast;
  ev_t elast;
  bit rhold = 0, ehold = 0;
  int checks = 0, passed = 0;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  function automatic logic [DW-1:0] mword(input int w, input int l, input int k);
    return {mdat[w][l][k*WS+3], mdat[w][l][k*WS+2], mdat[w][l][k*WS+1], mdat[w][l][k*WS]};
  endfunction
  task automatic step();
    int w, l;
    logic [NP*DW-1:0] rd;
    ev_t e;
    w = way_sel;
    l = addr;
    if (!stall) begin
      if (fill) begin
        for (int k = 0; k < WPL; k++)
          for (int b = 0; b < WS; b++) mdat[w][l][k*WS+b] = fill_data[k][b*8 +: 8];
        for (int j = 0; j < LB; j++) mdirty[w][l][j] = 0;
      end else if (write) begin
        for (int i = 0; i < NP; i++)
          for (int b = 0; b < WS; b++)
            if (pmask[i] && byteen[i][b]) begin
              mdat[w][l][wsel[i]*WS+b] = write_data[i][b*8 +: 8];
              mdirty[w][l][wsel[i]*WS+b] = 1;
            end
      end else if (evict) begin
        for (int k = 0; k < WPL; k++) e.d[k*DW +: DW] = mword(w, l, k);
        for (int j = 0; j < LB; j++) begin
          e.m[j] = mdirty[w][l][j];
          mdirty[w][l][j] = 0;
        end
        eq.push_back(e);
      end else if (read) begin
        for (int i = 0; i < NP; i++) rd[i*DW +: DW] = pmask[i] ? mword(w, l, int'(wsel[i])) : '0;
        rq.push_back(rd);
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    read = 0; write = 0; fill = 0; evict = 0;
  endtask
  task automatic do_reset();
    reset = 0;
    #1;
    chk("rst_read_valid", read_valid, 0);
    chk("rst_evict_valid", evict_valid, 0);
    chk("rst_read_data", read_data, 0);
    chk("rst_evict_byteen", evict_byteen, 0);
    rq.delete();
    eq.delete();
    for (int w = 0; w < NW; w++)
      for (int l = 0; l < NL; l++)
        for (int j = 0; j < LB; j++) mdirty[w][l][j] = 0;
    @(posedge clk);
    #1;
    reset = 1;
  endtask
  always @(negedge clk)
    if (!reset) begin
      rhold = 0;
      ehold = 0;
    end else begin
      if (read_valid) begin
        if (rhold) chk("read_hold_data", read_data, rlast);
        else if (rq.size() == 0) chk("read_unexpected", read_valid, 0);
        else begin
          rlast = rq.pop_front();
          chk("read_data", read_data, rlast);
        end
      end else if (rhold) chk("read_hold_valid", read_valid, 1);
      if (evict_valid) begin
        if (ehold) begin
          chk("evict_hold_data", evict_data, elast.d);
          chk("evict_hold_mask", evict_byteen, elast.m);
        end else if (eq.size() == 0) chk("evict_unexpected", evict_valid, 0);
        else begin
          elast = eq.pop_front();
          chk("evict_data", evict_data, elast.d);
          chk("evict_byteen", evict_byteen, elast.m);
        end
      end else if (ehold) chk("evict_hold_valid", evict_valid, 1);
      rhold = stall && read_valid;
      ehold = stall && evict_valid;
    end
  initial begin
    logic [NP-1:0][DW-1:0] held;
    logic [WPL-1:0][DW-1:0] fd;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    way_sel = 2; addr = 5;
    fill_data[0] = 32'h44; fill_data[1] = 32'h33; fill_data[2] = 32'h22; fill_data[3] = 32'h11;
    fill = 1; step(); idle();
    read = 1; pmask = 2'b11; wsel[0] = 3; wsel[1] = 0; step(); idle();
    chk("tp1_read_valid", read_valid, 1);
    chk("tp1_read_data", read_data, {32'h44, 32'h11});
    evict = 1; step(); idle();
    chk("tp1_evict_clean", evict_byteen, 0);
    write = 1; pmask = 2'b01; wsel[0] = 1; byteen[0] = 4'b0011; write_data[0] = 32'hAABBCCDD; step(); idle();
    evict = 1; step(); idle();
    chk("tp2_evict_word1", evict_data[1], 32'h0000CCDD);
    chk("tp2_evict_byteen", evict_byteen, 16'h0030);
    evict = 1; step(); idle();
    chk("tp2_evict_again", evict_byteen, 0);
    write = 1; pmask = 2'b11; wsel[0] = 2; wsel[1] = 2; byteen[0] = 4'hF; byteen[1] = 4'hF;
    write_data[0] = 32'h1111; write_data[1] = 32'h2222; step(); idle();
    read = 1; pmask = 2'b01; wsel[0] = 2; step(); idle();
    chk("tp3_collide", read_data[0], 32'h2222);
    read = 1; pmask = 2'b11; wsel[0] = 0; wsel[1] = 1; step(); idle();
    held = read_data;
    stall = 1;
    for (int c = 0; c < 3; c++) begin
      read = (c == 1);
      step();
      chk("tp4_stall_valid", read_valid, 1);
      chk("tp4_stall_data", read_data, held);
    end
    idle(); stall = 0; step();
    chk("tp4_release_drop", read_valid, 0);
    way_sel = 1; addr = 7;
    for (int k = 0; k < WPL; k++) fd[k] = $urandom;
    fill_data = fd; fill = 1; write = 1; pmask = 2'b11; byteen[0] = 4'hF; byteen[1] = 4'hF; step(); idle();
    evict = 1; step(); idle();
    chk("tp5_fill_wins_data", evict_data, fd);
    chk("tp5_fill_wins_mask", evict_byteen, 0);
    way_sel = 2; addr = 5;
    write = 1; pmask = 2'b01; wsel[0] = 0; byteen[0] = 4'b1000; write_data[0] = 32'h5A000000; step(); idle();
    read = 1; step(); idle();
    chk("tp6_pending", read_valid, 1);
    do_reset();
    evict = 1; step(); idle();
    chk("tp6_evict_after_reset", evict_byteen, 0);
    for (int w = 0; w < NW; w++)
      for (int l = 0; l < 8; l++) begin
        way_sel = w; addr = l;
        for (int k = 0; k < WPL; k++) fill_data[k] = $urandom;
        fill = 1; step(); idle();
      end
    for (int c = 0; c < 600; c++) begin
      stall = ($urandom_range(0, 4) == 0);
      fill = ($urandom_range(0, 9) == 0);
      write = ($urandom_range(0, 2) == 0);
      evict = ($urandom_range(0, 3) == 0);
      read = ($urandom_range(0, 1) == 0);
      way_sel = $urandom_range(0, 3);
      addr = $urandom_range(0, 7);
      pmask = $urandom;
      for (int i = 0; i < NP; i++) begin
        wsel[i] = $urandom;
        byteen[i] = $urandom;
        write_data[i] = $urandom;
      end
      for (int k = 0; k < WPL; k++) fill_data[k] = $urandom;
      step();
    end
    idle(); stall = 0;
    repeat (4) step();
    chk("rq_drained", rq.size(), 0);
    chk("eq_drained", eq.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
